posit_normalize_stream: RTL and testbench

POSIT_NORMALIZE_STREAM -- requirements
Module: posit_normalize_stream

---
 rtl/posit_normalize_stream.sv | 212 +++++++++++++++++++++
 tb/tb_posit_normalize_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_normalize_stream.sv
// Posit encoder stream: packs sign/scale/fraction/GRS into a rounded POSIT_WIDTH-bit posit.
// Three-stage pipeline with a global stall driven by output backpressure.
module posit_normalize_stream #(
    parameter int unsigned POSIT_WIDTH = 32,
    parameter int unsigned POSIT_ES    = 2,
    parameter int unsigned SCALE_W     = $clog2(POSIT_WIDTH) + POSIT_ES + 2,
    parameter int unsigned FRAC_W      = POSIT_WIDTH - POSIT_ES - 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic                   in_zero,
    input  logic                   in_nar,
    input  logic [SCALE_W-1:0]     in_scale,
    input  logic [FRAC_W-1:0]      in_fraction,
    input  logic [2:0]             in_grs,
    input  logic [2:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [POSIT_WIDTH-1:0] out_posit,
    output logic [15:0]            sat_hi_cnt,
    output logic [15:0]            sat_lo_cnt,
    input  logic                   cnt_clr
);

    localparam int unsigned MW        = POSIT_WIDTH - 1;
    localparam int unsigned LW        = 2 * POSIT_WIDTH + 1;
    localparam int unsigned SH_W      = $clog2(POSIT_WIDTH + 1);
    localparam int          MAX_SCALE = int'(1 << POSIT_ES) * int'(POSIT_WIDTH - 2);

    localparam logic [2:0] RM_RZERO    = 3'd0;
    localparam logic [2:0] RM_RPLUSINF = 3'd2;
    localparam logic [2:0] RM_RMININF  = 3'd3;
    localparam logic [2:0] RM_STOCH    = 3'd4;

    logic stall;
    logic accept;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~stall;
    assign accept   = in_valid & in_ready;

    // Stochastic-rounding source, stepped once per accepted beat
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // S1: regime run length, exponent/fraction tail and clamp detection
    int                     scale_i;
    int                     k_i;
    int                     run_i;
    logic                   rb_c;
    logic                   hi_c;
    logic                   lo_c;
    logic [POSIT_WIDTH-1:0] tail_c;
    logic [LW-1:0]          pat_c;
    logic [SH_W-1:0]        sh_c;

    always_comb begin
        scale_i = int'($signed(in_scale));
        k_i     = scale_i >>> POSIT_ES;
        rb_c    = (k_i >= 0);
        run_i   = rb_c ? (k_i + 1) : -k_i;
        hi_c    = (scale_i > MAX_SCALE);
        lo_c    = (scale_i < -MAX_SCALE);
        tail_c  = (POSIT_WIDTH'(in_scale & SCALE_W'((1 << POSIT_ES) - 1)) << (FRAC_W + 3))
                | POSIT_WIDTH'({in_fraction, in_grs});
        // Every bit above the terminator holds the regime bit; the S2 shift trims the run
        pat_c   = {{POSIT_WIDTH{rb_c}}, ~rb_c, tail_c};
        sh_c    = '0;
        if (!(hi_c || lo_c)) begin
            sh_c = SH_W'(int'(POSIT_WIDTH) - run_i);
        end
    end

    logic                   s1_valid, s1_sign, s1_nar, s1_zero, s1_hi, s1_lo;
    logic [2:0]             s1_mode, s1_rnd;
    logic [LW-1:0]          s1_pat;
    logic [SH_W-1:0]        s1_sh;

    // S2: align regime, keep top magnitude bits, fold the rest into G/R/S
    logic [LW-1:0]          shifted_c;
    logic [2:0]             grs_c;

    always_comb begin
        shifted_c = s1_pat << s1_sh;
        grs_c     = {shifted_c[LW-1-MW], shifted_c[LW-2-MW], |shifted_c[LW-3-MW:0]};
    end

    logic                   s2_valid, s2_sign, s2_nar, s2_zero, s2_hi, s2_lo;
    logic [2:0]             s2_mode, s2_rnd, s2_grs;
    logic [MW-1:0]          s2_mag;

    // S3: rounding increment, saturation, complement and special values
    logic                   ulp_c;
    logic [MW:0]            sum_c;
    logic [MW-1:0]          mag_c;
    logic [POSIT_WIDTH-1:0] posit_c;

    always_comb begin
        ulp_c = 1'b0;
        case (s2_mode)
            RM_RZERO:    ulp_c = 1'b0;
            RM_RPLUSINF: ulp_c = ~s2_sign & (|s2_grs);
            RM_RMININF:  ulp_c = s2_sign & (|s2_grs);
            RM_STOCH:    ulp_c = (s2_grs > s2_rnd);
            default:     ulp_c = s2_grs[2] & (s2_grs[1] | s2_grs[0] | s2_mag[0]);
        endcase
        sum_c = {1'b0, s2_mag} + {{MW{1'b0}}, ulp_c};
        mag_c = sum_c[MW] ? {MW{1'b1}} : sum_c[MW-1:0];
        if (mag_c == '0) begin
            mag_c = MW'(1);
        end
        posit_c = {s2_sign, s2_sign ? (~mag_c + MW'(1)) : mag_c};
        // Clamped beats skip rounding and complement: sign prepended to the saturated magnitude
        if (s2_hi) begin
            posit_c = {s2_sign, {MW{1'b1}}};
        end else if (s2_lo) begin
            posit_c = {s2_sign, MW'(1)};
        end
        if (s2_zero) begin
            posit_c = '0;
        end
        if (s2_nar) begin
            posit_c = {1'b1, {MW{1'b0}}};
        end
    end

    logic s3_hi, s3_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_nar    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_hi     <= 1'b0;
            s1_lo     <= 1'b0;
            s1_mode   <= '0;
            s1_rnd    <= '0;
            s1_pat    <= '0;
            s1_sh     <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nar    <= 1'b0;
            s2_zero   <= 1'b0;
            s2_hi     <= 1'b0;
            s2_lo     <= 1'b0;
            s2_mode   <= '0;
            s2_rnd    <= '0;
            s2_grs    <= '0;
            s2_mag    <= '0;
            out_valid <= 1'b0;
            out_posit <= '0;
            s3_hi     <= 1'b0;
            s3_lo     <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            s1_sign   <= in_sign;
            s1_nar    <= in_nar;
            s1_zero   <= in_zero & ~in_nar;
            s1_hi     <= hi_c;
            s1_lo     <= lo_c;
            s1_mode   <= rnd_mode;
            s1_rnd    <= lfsr[2:0];
            s1_pat    <= pat_c;
            s1_sh     <= sh_c;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_nar    <= s1_nar;
            s2_zero   <= s1_zero;
            s2_hi     <= s1_hi;
            s2_lo     <= s1_lo;
            s2_mode   <= s1_mode;
            s2_rnd    <= s1_rnd;
            s2_grs    <= grs_c;
            s2_mag    <= shifted_c[LW-1 -: MW];
            out_valid <= s2_valid;
            out_posit <= posit_c;
            s3_hi     <= s2_hi & ~s2_nar & ~s2_zero;
            s3_lo     <= s2_lo & ~s2_nar & ~s2_zero;
        end
    end

    // Clamp counters count on delivery, saturate, and yield to a clear
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sat_hi_cnt <= '0;
            sat_lo_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (s3_hi && (sat_hi_cnt != 16'hFFFF)) begin
                sat_hi_cnt <= sat_hi_cnt + 16'd1;
            end
            if (s3_lo && (sat_lo_cnt != 16'hFFFF)) begin
                sat_lo_cnt <= sat_lo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_posit_normalize_stream.sv
// Scoreboard bench for posit_normalize_stream at POSIT_WIDTH=8, ES=0.
module tb_posit_normalize_stream;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic       in_zero;
    logic       in_nar;
    logic [4:0] in_scale;
    logic [4:0] in_fraction;
    logic [2:0] in_grs;
    logic [2:0] rnd_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_posit;
    logic [15:0] sat_hi_cnt;
    logic [15:0] sat_lo_cnt;
    logic       cnt_clr;

    posit_normalize_stream #(
        .POSIT_WIDTH(8),
        .POSIT_ES   (0),
        .SCALE_W    (5),
        .FRAC_W     (5),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_zero    (in_zero),
        .in_nar     (in_nar),
        .in_scale   (in_scale),
        .in_fraction(in_fraction),
        .in_grs     (in_grs),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_posit  (out_posit),
        .sat_hi_cnt (sat_hi_cnt),
        .sat_lo_cnt (sat_lo_cnt),
        .cnt_clr    (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0] val;
        int         acc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   tot = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        tot++;
        bad++;
        $display("FAIL %s: got no event, wanted one (cycle %0d)", name, cyc);
    endtask

    // Issue one beat at a falling edge; returns at the falling edge after acceptance
    task automatic send(input logic sg, input logic zr, input logic nr, input logic [4:0] sc,
                        input logic [4:0] fr, input logic [2:0] gr, input logic [2:0] md,
                        input logic [7:0] ev, input bit lat);
        bit done;
        exp_t e;
        done        = 1'b0;
        in_valid    = 1'b1;
        in_sign     = sg;
        in_zero     = zr;
        in_nar      = nr;
        in_scale    = sc;
        in_fraction = fr;
        in_grs      = gr;
        rnd_mode    = md;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (in_ready) begin
                e.val = ev;
                e.acc = cyc;
                e.lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) fail("send_timeout");
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 60 && !empty; i++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0) empty = 1'b1;
        end
        if (!empty) fail("drain_timeout");
        @(negedge clk);
    endtask

    // Monitor: latency on first presentation, hold stability under stall, value on handshake
    bit         held = 1'b0;
    logic [7:0] held_val = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                sb.delete();
                held = 1'b0;
            end else begin
                if (held && !out_valid) fail("valid_dropped_in_stall");
                if (out_valid) begin
                    if (held) begin
                        chk("held_posit", 32'(out_posit), 32'(held_val));
                    end else if (sb.size() == 0) begin
                        tot++;
                        bad++;
                        $display("FAIL unexpected_beat: got %0h, wanted no beat", out_posit);
                    end else if (sb[0].lat) begin
                        chk("latency", 32'(cyc - sb[0].acc), 32'd3);
                    end
                    if (out_ready) begin
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("posit", 32'(out_posit), 32'(e.val));
                        end
                        held = 1'b0;
                    end else begin
                        held     = 1'b1;
                        held_val = out_posit;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_zero     = 1'b0;
        in_nar      = 1'b0;
        in_scale    = '0;
        in_fraction = '0;
        in_grs      = '0;
        rnd_mode    = '0;
        out_ready   = 1'b1;
        cnt_clr     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_posit", 32'(out_posit), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sat_hi", 32'(sat_hi_cnt), 32'd0);
        chk("rst_sat_lo", 32'(sat_lo_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed encodings, back to back
        send(0, 0, 0, 5'd0,    5'b00000, 3'b000, 3'd1, 8'h40, 1);
        send(0, 0, 0, 5'd1,    5'b00000, 3'b000, 3'd1, 8'h60, 1);
        send(1, 0, 0, 5'd0,    5'b00000, 3'b000, 3'd1, 8'hC0, 1);
        send(0, 0, 0, 5'd0,    5'b00000, 3'b100, 3'd1, 8'h40, 1);
        send(0, 0, 0, 5'd0,    5'b00001, 3'b100, 3'd1, 8'h42, 1);
        send(0, 0, 0, 5'd0,    5'b00000, 3'b101, 3'd0, 8'h40, 1);
        send(0, 0, 0, 5'd0,    5'b00000, 3'b101, 3'd2, 8'h41, 1);
        send(1, 0, 0, 5'd0,    5'b00000, 3'b101, 3'd3, 8'hBF, 1);
        send(0, 0, 0, 5'd0,    5'b00001, 3'b100, 3'd5, 8'h42, 1);
        send(0, 0, 0, 5'd2,    5'b11111, 3'b111, 3'd1, 8'h78, 1);
        send(0, 0, 0, 5'h1F,   5'b10101, 3'b000, 3'd1, 8'h35, 1);
        send(0, 0, 0, 5'd6,    5'b11111, 3'b111, 3'd2, 8'h7F, 1);
        send(0, 0, 0, 5'h1A,   5'b00000, 3'b000, 3'd0, 8'h01, 1);
        send(0, 0, 0, 5'd7,    5'b00000, 3'b000, 3'd1, 8'h7F, 1);
        send(1, 0, 0, 5'h19,   5'b00000, 3'b000, 3'd1, 8'h81, 1);
        send(0, 0, 1, 5'd7,    5'b00000, 3'b000, 3'd1, 8'h80, 1);
        send(0, 1, 0, 5'h19,   5'b00000, 3'b000, 3'd1, 8'h00, 1);
        send(0, 1, 1, 5'd0,    5'b00000, 3'b000, 3'd1, 8'h80, 1);
        in_valid = 1'b0;
        drain();
        chk("sat_hi_after_clamps", 32'(sat_hi_cnt), 32'd1);
        chk("sat_lo_after_clamps", 32'(sat_lo_cnt), 32'd1);

        // Clear pulse coinciding with a clamped beat leaving the pipeline
        send(0, 0, 0, 5'd7, 5'b00000, 3'b000, 3'd1, 8'h7F, 1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        #1;
        chk("sat_hi_after_clr", 32'(sat_hi_cnt), 32'd0);
        chk("sat_lo_after_clr", 32'(sat_lo_cnt), 32'd0);
        drain();
        send(1, 0, 0, 5'h19, 5'b00000, 3'b000, 3'd1, 8'h81, 1);
        in_valid = 1'b0;
        drain();
        chk("sat_lo_recount", 32'(sat_lo_cnt), 32'd1);
        chk("sat_hi_recount", 32'(sat_hi_cnt), 32'd0);

        // Backpressure: hold out_ready low for 5 cycles from the first output
        fork
            begin
                send(0, 0, 0, 5'd0, 5'b00000, 3'b000, 3'd1, 8'h40, 0);
                send(0, 0, 0, 5'd1, 5'b00000, 3'b000, 3'd1, 8'h60, 0);
                send(1, 0, 0, 5'd0, 5'b00000, 3'b000, 3'd1, 8'hC0, 0);
                send(0, 0, 0, 5'd0, 5'b00001, 3'b100, 3'd1, 8'h42, 0);
                in_valid = 1'b0;
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 30 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1'b1;
                end
                if (!seen) begin
                    fail("bp_first_valid");
                end else begin
                    out_ready = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        #1;
                        chk("stall_in_ready", 32'(in_ready), 32'd0);
                        @(negedge clk);
                    end
                    out_ready = 1'b1;
                end
            end
        join
        drain();

        // Reset with beats in flight, then stochastic beats from the reseeded LFSR
        send(0, 0, 0, 5'd0, 5'b00000, 3'b000, 3'd1, 8'h40, 1);
        send(0, 0, 0, 5'd1, 5'b00000, 3'b000, 3'd1, 8'h60, 1);
        send(1, 0, 0, 5'd0, 5'b00000, 3'b000, 3'd1, 8'hC0, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_sat_lo", 32'(sat_lo_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(0, 0, 0, 5'd0, 5'b00000, 3'b010, 3'd4, 8'h41, 1);
        send(0, 0, 0, 5'd0, 5'b00000, 3'b011, 3'd4, 8'h40, 1);
        send(0, 0, 0, 5'd0, 5'b00000, 3'b111, 3'd4, 8'h40, 1);
        in_valid = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
